// File: rtl/i2c_master_ext.sv
// i2c_master_ext: I2C master byte engine with open-drain SCL/SDA, clock
// stretching with timeout abort, multi-master arbitration-loss detection
// and host-selected ACK/NACK on reads.
module i2c_master_ext #(
  parameter int unsigned DVSR_W      = 16,
  parameter int unsigned STRETCH_W   = 20,
  parameter int unsigned STRETCH_MAX = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_i2c,
  input  logic [2:0]        cmd,
  input  logic [7:0]        data_in,
  input  logic [DVSR_W-1:0] dvsr,
  output logic [7:0]        data_out,
  output logic              ack,
  output logic              ready,
  output logic              done_tick,
  output logic              arb_lost,
  output logic              timeout,
  input  logic              sda_i,
  input  logic              scl_i,
  output logic              sda_o,
  output logic              scl_o
);

  localparam logic [2:0] CMD_START   = 3'b000;
  localparam logic [2:0] CMD_WR      = 3'b001;
  localparam logic [2:0] CMD_RD      = 3'b010;
  localparam logic [2:0] CMD_STOP    = 3'b011;
  localparam logic [2:0] CMD_RESTART = 3'b100;
  localparam int unsigned CNT_W = DVSR_W + 1;

  typedef enum logic [3:0] {
    IDLE, S1, S2, HOLD, R1, R2, P1, P2, P3, D1, D2, D3, D4, DEND
  } state_t;

  state_t               state;
  logic [DVSR_W-1:0]    dv;
  logic [CNT_W-1:0]     cnt;
  logic [STRETCH_W-1:0] stretch;
  logic [8:0]           tx;
  logic [8:0]           rx;
  logic [3:0]           bit_idx;
  logic                 is_rd;

  logic [DVSR_W-1:0]    dvsr_eff;
  logic [CNT_W-1:0]     plen;
  logic                 phase_end;
  logic                 stretch_hit;
  logic                 arb_chk;
  logic                 arb_hit;
  logic                 accept;

  // Phase length (P3 is the doubled bus-free time), divisor floor, abort conditions
  assign dvsr_eff    = (dvsr == '0) ? DVSR_W'(1) : dvsr;
  assign plen        = (state == P3) ? {dv, 1'b0} : {1'b0, dv};
  assign phase_end   = (cnt == plen - CNT_W'(1));
  assign stretch_hit = (stretch == STRETCH_W'(STRETCH_MAX - 1));
  assign arb_chk     = is_rd ? (bit_idx == 4'd8) : (bit_idx != 4'd8);
  assign arb_hit     = arb_chk && scl_i && sda_o && !sda_i;
  assign accept      = wr_i2c && ready;

  // Bus sequencer: phase timing, bit shifting, stretch and arbitration handling
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sda_o     <= 1'b1;
      scl_o     <= 1'b1;
      ready     <= 1'b1;
      done_tick <= 1'b0;
      arb_lost  <= 1'b0;
      timeout   <= 1'b0;
      ack       <= 1'b0;
      data_out  <= '0;
      dv        <= DVSR_W'(1);
      cnt       <= '0;
      stretch   <= '0;
      tx        <= '1;
      rx        <= '0;
      bit_idx   <= '0;
      is_rd     <= 1'b0;
    end else begin
      done_tick <= 1'b0;
      arb_lost  <= 1'b0;
      timeout   <= 1'b0;
      cnt       <= cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          if (accept && cmd == CMD_START) begin
            dv    <= dvsr_eff;
            cnt   <= '0;
            ready <= 1'b0;
            sda_o <= 1'b0;
            scl_o <= 1'b1;
            state <= S1;
          end
        end
        S1: begin
          if (phase_end) begin
            cnt   <= '0;
            scl_o <= 1'b0;
            state <= S2;
          end
        end
        S2: begin
          if (phase_end) begin
            cnt   <= '0;
            ready <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (accept) begin
            case (cmd)
              CMD_WR, CMD_RD: begin
                dv      <= dvsr_eff;
                cnt     <= '0;
                ready   <= 1'b0;
                is_rd   <= (cmd == CMD_RD);
                tx      <= (cmd == CMD_RD) ? {8'hFF, data_in[0]} : {data_in, 1'b1};
                sda_o   <= (cmd == CMD_RD) ? 1'b1 : data_in[7];
                bit_idx <= '0;
                state   <= D1;
              end
              CMD_START, CMD_RESTART: begin
                dv    <= dvsr_eff;
                cnt   <= '0;
                ready <= 1'b0;
                sda_o <= 1'b1;
                state <= R1;
              end
              CMD_STOP: begin
                dv    <= dvsr_eff;
                cnt   <= '0;
                ready <= 1'b0;
                sda_o <= 1'b0;
                state <= P1;
              end
              default: ;
            endcase
          end
        end
        R1: begin
          if (phase_end) begin
            cnt     <= '0;
            scl_o   <= 1'b1;
            stretch <= '0;
            state   <= R2;
          end
        end
        P1: begin
          if (phase_end) begin
            cnt     <= '0;
            scl_o   <= 1'b1;
            stretch <= '0;
            state   <= P2;
          end
        end
        D1: begin
          if (phase_end) begin
            cnt     <= '0;
            scl_o   <= 1'b1;
            stretch <= '0;
            state   <= D2;
          end
        end
        R2, P2, D2: begin
          if (!scl_i) begin
            // slave holds SCL: freeze the phase count and run the stretch timer
            cnt <= cnt;
            if (stretch_hit) begin
              timeout <= 1'b1;
              sda_o   <= 1'b1;
              scl_o   <= 1'b1;
              ready   <= 1'b1;
              stretch <= '0;
              state   <= IDLE;
            end else begin
              stretch <= stretch + STRETCH_W'(1);
            end
          end else begin
            stretch <= '0;
            if (state == D2 && arb_hit) begin
              arb_lost <= 1'b1;
              sda_o    <= 1'b1;
              scl_o    <= 1'b1;
              ready    <= 1'b1;
              state    <= IDLE;
            end else if (phase_end) begin
              cnt <= '0;
              case (state)
                R2: begin
                  sda_o <= 1'b0;
                  state <= S1;
                end
                P2: begin
                  sda_o <= 1'b1;
                  state <= P3;
                end
                default: state <= D3;
              endcase
            end
          end
        end
        P3: begin
          if (phase_end) begin
            cnt   <= '0;
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        D3: begin
          if (arb_hit) begin
            arb_lost <= 1'b1;
            sda_o    <= 1'b1;
            scl_o    <= 1'b1;
            ready    <= 1'b1;
            state    <= IDLE;
          end else if (phase_end) begin
            cnt   <= '0;
            rx    <= {rx[7:0], sda_i};
            scl_o <= 1'b0;
            state <= D4;
          end
        end
        D4: begin
          if (phase_end) begin
            cnt <= '0;
            tx  <= {tx[7:0], 1'b0};
            if (bit_idx == 4'd8) begin
              state <= DEND;
            end else begin
              bit_idx <= bit_idx + 4'd1;
              sda_o   <= tx[7];
              state   <= D1;
            end
          end
        end
        DEND: begin
          if (phase_end) begin
            cnt       <= '0;
            data_out  <= rx[8:1];
            ack       <= rx[0];
            done_tick <= 1'b1;
            ready     <= 1'b1;
            state     <= HOLD;
          end
        end
        default: begin
          sda_o <= 1'b1;
          scl_o <= 1'b1;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_ext.sv
// Bench for i2c_master_ext: a phase-level bus model expands each command
// into a per-cycle script of stimulus plus expected outputs; one process
// replays the script and compares every cycle.
module tb_i2c_master_ext;

  localparam int unsigned DVSR_W    = 16;
  localparam int unsigned STRETCH_W = 20;
  localparam int unsigned SMAX      = 1000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_i2c = 1'b0;
  logic [2:0]        cmd = 3'd0;
  logic [7:0]        data_in = 8'd0;
  logic [DVSR_W-1:0] dvsr = DVSR_W'(1);
  logic [7:0]        data_out;
  logic              ack, ready, done_tick, arb_lost, timeout;
  logic              sda_i, scl_i, sda_o, scl_o;
  logic              slv_hold = 1'b0;
  logic              slv_sda = 1'b1;

  // open-drain wired-AND bus with a slave / competing master
  assign sda_i = sda_o & slv_sda;
  assign scl_i = scl_o & ~slv_hold;

  i2c_master_ext #(.DVSR_W(DVSR_W), .STRETCH_W(STRETCH_W), .STRETCH_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .wr_i2c(wr_i2c), .cmd(cmd), .data_in(data_in), .dvsr(dvsr),
    .data_out(data_out), .ack(ack), .ready(ready), .done_tick(done_tick),
    .arb_lost(arb_lost), .timeout(timeout), .sda_i(sda_i), .scl_i(scl_i),
    .sda_o(sda_o), .scl_o(scl_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        r_rst;
    logic        wr;
    logic [2:0]  cmd;
    logic [7:0]  din;
    logic [15:0] dvsr;
    logic        hold;
    logic        ssda;
    logic        chk;
    logic        e_scl, e_sda, e_rdy, e_done, e_arb, e_to, e_ack;
    logic [7:0]  e_do;
  } rec_t;

  rec_t q[$];

  bit         m_idle;
  logic       m_sda;
  logic [7:0] m_do;
  logic       m_ack;
  bit         p_done, p_arb, p_to;
  int         m_dv;
  int         ncmp = 0;
  int         nfail = 0;

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic pin(input string nm, input int got, input int want);
    ncmp++;
    if (got != want) begin
      nfail++;
      $display("FAIL model %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // n cycles of given line levels; busy cycles carry junk command strobes
  task automatic push(input int n, input logic scl, input logic sda, input logic rdy,
                      input logic hold, input logic ssda);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      r = '0;
      r.chk  = 1'b1;
      r.wr   = rdy ? 1'b0 : 1'($urandom_range(0, 1));
      r.cmd  = 3'($urandom);
      r.din  = 8'($urandom);
      r.dvsr = 16'($urandom);
      r.hold = hold;
      r.ssda = ssda;
      r.e_scl = scl; r.e_sda = sda; r.e_rdy = rdy;
      r.e_done = p_done; r.e_arb = p_arb; r.e_to = p_to;
      p_done = 1'b0; p_arb = 1'b0; p_to = 1'b0;
      r.e_do = m_do; r.e_ack = m_ack;
      q.push_back(r);
    end
  endtask

  task automatic ready_cycles(input int n);
    if (m_idle) push(n, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    else        push(n, 1'b0, m_sda, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic issue(input logic [2:0] c, input logic [7:0] d, input int dv_in);
    rec_t r;
    ready_cycles(1);
    r = q.pop_back();
    r.wr = 1'b1; r.cmd = c; r.din = d; r.dvsr = 16'(dv_in);
    q.push_back(r);
  endtask

  task automatic start(input int dv_in);
    issue(3'd0, 8'($urandom), dv_in);
    m_dv = eff(dv_in);
    push(m_dv, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(m_dv, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    m_sda = 1'b0; m_idle = 1'b0;
  endtask

  task automatic restart(input logic [2:0] c, input int dv_in);
    issue(c, 8'($urandom), dv_in);
    m_dv = eff(dv_in);
    push(m_dv, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    push(m_dv, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    push(m_dv, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(m_dv, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    m_sda = 1'b0;
  endtask

  task automatic stop(input int dv_in, input int st);
    issue(3'd3, 8'($urandom), dv_in);
    m_dv = eff(dv_in);
    push(m_dv, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(st,   1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    push(m_dv, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(2 * m_dv, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    m_idle = 1'b1; m_sda = 1'b1;
  endtask

  // one byte; ev: 0 none, 1 stretch st cycles in SCL-high of bit evb,
  // 2 competing master pulls SDA at bit evb, 3 reset during bit evb high
  task automatic xfer(input logic rd, input logic [7:0] din, input int dv_in,
                      input logic [7:0] sbyte, input logic sack,
                      input int ev, input int evb, input int st);
    logic [8:0] tx;
    logic [8:0] rxv;
    logic mb, ss;
    rec_t r;
    issue(rd ? 3'd2 : 3'd1, din, dv_in);
    m_dv = eff(dv_in);
    tx = rd ? {8'hFF, din[0]} : {din, 1'b1};
    rxv = '0;
    mb = 1'b1;
    for (int i = 0; i < 9; i++) begin
      mb = tx[8 - i];
      if (rd) ss = (i < 8) ? sbyte[7 - i] : 1'b1;
      else    ss = (i < 8) ? 1'b1 : sack;
      push(m_dv, 1'b0, mb, 1'b0, 1'b0, ss);
      if (ev == 1 && i == evb) begin
        if (st >= int'(SMAX)) begin
          push(SMAX, 1'b1, mb, 1'b0, 1'b1, ss);
          m_idle = 1'b1; m_sda = 1'b1; p_to = 1'b1;
          return;
        end
        push(st, 1'b1, mb, 1'b0, 1'b1, ss);
      end
      if (ev == 2 && i == evb) begin
        push(1, 1'b1, mb, 1'b0, 1'b0, 1'b0);
        m_idle = 1'b1; m_sda = 1'b1; p_arb = 1'b1;
        return;
      end
      push(m_dv, 1'b1, mb, 1'b0, 1'b0, ss);
      if (ev == 3 && i == evb) begin
        push(m_dv, 1'b1, mb, 1'b0, 1'b0, ss);
        r = q.pop_back();
        r.r_rst = 1'b1; r.wr = 1'b0;
        q.push_back(r);
        m_idle = 1'b1; m_sda = 1'b1; m_do = 8'h00; m_ack = 1'b0;
        return;
      end
      push(m_dv, 1'b1, mb, 1'b0, 1'b0, ss);
      rxv = {rxv[7:0], mb & ss};
      push(m_dv, 1'b0, mb, 1'b0, 1'b0, ss);
    end
    push(m_dv, 1'b0, mb, 1'b0, 1'b0, 1'b1);
    m_sda = mb;
    m_do = rxv[8:1]; m_ack = rxv[0]; p_done = 1'b1;
  endtask

  task automatic build();
    rec_t r;
    int s0;
    logic rd;
    logic [7:0] d;
    int ev, evb, st, roll, nb;
    r = '0;
    r.r_rst = 1'b1; r.dvsr = 16'd1; r.ssda = 1'b1;
    q.push_back(r);
    m_idle = 1'b1; m_sda = 1'b1; m_do = 8'h00; m_ack = 1'b0;
    p_done = 1'b0; p_arb = 1'b0; p_to = 1'b0; m_dv = 1;
    ready_cycles(3);

    // non-start commands in IDLE are ignored
    for (int c = 1; c <= 4; c++) begin
      issue(3'(c), 8'($urandom), 3);
      ready_cycles(2);
    end

    // two writes and a stop at dvsr=250
    start(250);
    s0 = q.size();
    xfer(1'b0, 8'h55, 250, 8'h00, 1'b0, 0, 0, 0);
    pin("wr_byte_len", q.size() - s0, 9251);
    pin("wr1_data", int'(m_do), 8'h55);
    xfer(1'b0, 8'hAA, 250, 8'h00, 1'b0, 0, 0, 0);
    pin("wr2_data", int'(m_do), 8'hAA);
    pin("wr2_ack", int'(m_ack), 0);
    ready_cycles(5);
    s0 = q.size();
    stop(250, 0);
    pin("stop_len", q.size() - s0, 1001);
    ready_cycles(5);

    // write then NACKed read; reserved command in HOLD ignored
    start(4);
    issue(3'd5, 8'h00, 2);
    ready_cycles(2);
    xfer(1'b0, 8'hAB, 4, 8'h00, 1'b0, 0, 0, 0);
    xfer(1'b1, 8'h01, 4, 8'hF0, 1'b0, 0, 0, 0);
    pin("rd_data", int'(m_do), 8'hF0);
    pin("rd_ack", int'(m_ack), 1);
    stop(4, 0);
    ready_cycles(3);

    // 300-cycle stretch in bit 3
    start(5);
    xfer(1'b0, 8'hC3, 5, 8'h00, 1'b0, 1, 2, 300);
    stop(5, 3);
    ready_cycles(3);

    // permanent stretch after start -> timeout
    start(3);
    s0 = q.size();
    xfer(1'b0, 8'h3C, 3, 8'h00, 1'b0, 1, 0, SMAX);
    pin("timeout_delay", q.size() - (s0 + 1 + 3), 1000);
    ready_cycles(4);

    // arbitration lost at bit 2
    start(4);
    xfer(1'b0, 8'hFF, 4, 8'h00, 1'b0, 2, 1, 0);
    ready_cycles(4);

    // reset during bit 5 high phase
    start(3);
    xfer(1'b0, 8'h5A, 3, 8'h00, 1'b0, 3, 4, 0);
    ready_cycles(4);

    // restarts (both encodings) and dvsr=0
    start(0);
    xfer(1'b0, 8'h81, 0, 8'h00, 1'b1, 0, 0, 0);
    restart(3'd4, 2);
    xfer(1'b1, 8'h00, 2, 8'h3E, 1'b0, 0, 0, 0);
    restart(3'd0, 1);
    stop(0, 7);
    ready_cycles(3);

    // randomized transactions
    for (int t = 0; t < 25; t++) begin
      start($urandom_range(0, 5));
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        if (m_idle) break;
        rd = 1'($urandom_range(0, 1));
        d = 8'($urandom);
        ev = 0; evb = 0; st = 0;
        roll = $urandom_range(0, 99);
        if (roll < 25) begin
          ev = 1; evb = $urandom_range(0, 8); st = $urandom_range(1, 40);
        end else if (roll < 31) begin
          ev = 2;
          if (rd) begin evb = 8; d[0] = 1'b1; end
          else begin evb = $urandom_range(0, 7); d[7 - evb] = 1'b1; end
        end else if (roll < 34) begin
          ev = 1; evb = $urandom_range(0, 8); st = SMAX;
        end else if (roll < 37) begin
          ev = 3; evb = $urandom_range(0, 8);
        end
        xfer(rd, d, $urandom_range(0, 5), 8'($urandom), 1'($urandom_range(0, 1)), ev, evb, st);
        if (!m_idle && $urandom_range(0, 3) == 0)
          restart(($urandom_range(0, 1) == 1) ? 3'd4 : 3'd0, $urandom_range(0, 5));
      end
      if (!m_idle) stop($urandom_range(0, 5), $urandom_range(0, 5));
      ready_cycles($urandom_range(1, 4));
    end
  endtask

  // replay the script: drive inputs and compare outputs on the falling edge
  initial begin
    rec_t r;
    int cyc;
    logic [14:0] got, want;
    build();
    cyc = 0;
    while (q.size() > 0 && nfail < 50) begin
      r = q.pop_front();
      @(negedge clk);
      rst = r.r_rst; wr_i2c = r.wr; cmd = r.cmd; data_in = r.din;
      dvsr = DVSR_W'(r.dvsr); slv_hold = r.hold; slv_sda = r.ssda;
      if (r.chk) begin
        ncmp++;
        got  = {scl_o, sda_o, ready, done_tick, arb_lost, timeout, ack, data_out};
        want = {r.e_scl, r.e_sda, r.e_rdy, r.e_done, r.e_arb, r.e_to, r.e_ack, r.e_do};
        if (got !== want) begin
          nfail++;
          $display("FAIL cycle %0d outputs {scl,sda,rdy,done,arb,to,ack,do}: got %b_%h want %b_%h",
                   cyc, got[14:8], got[7:0], want[14:8], want[7:0]);
        end
      end
      cyc++;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
